// File: rtl/m_useq.sv
// Microcode sequencer for the midgetv ucode store: produces the registered
// micro-address and the hold strobe, handling dispatch, bus waits, shifts and traps.
module m_useq #(
  parameter logic [7:0]  UADR_RESET  = 8'h00,
  parameter logic [7:0]  UADR_IRQ    = 8'hF0,
  parameter logic [7:0]  UADR_BUSERR = 8'hF8,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] seq_op,
  input  logic [7:0] dispatch_idx,
  input  logic       instr_valid,
  input  logic       irq_pending,
  input  logic       ack,
  input  logic [4:0] shamt,
  output logic [7:0] minx,
  output logic       progress_ucode,
  output logic       shift_en,
  output logic       buserr
);

  localparam logic [1:0] OP_INC      = 2'd0;
  localparam logic [1:0] OP_DISPATCH = 2'd1;
  localparam logic [1:0] OP_WAITACK  = 2'd2;
  localparam logic [1:0] OP_SHIFT    = 2'd3;
  localparam logic [7:0] TMO         = 8'(ACK_TIMEOUT);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_SHIFT} state_t;

  state_t     state_q, state_d;
  logic [7:0] minx_q, minx_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic [4:0] scnt_q, scnt_d;
  logic       prog_q, prog_d;
  logic       shen_q, shen_d;
  logic       berr_q, berr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      minx_q  <= UADR_RESET;
      tcnt_q  <= '0;
      scnt_q  <= '0;
      prog_q  <= 1'b1;
      shen_q  <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      minx_q  <= minx_d;
      tcnt_q  <= tcnt_d;
      scnt_q  <= scnt_d;
      prog_q  <= prog_d;
      shen_q  <= shen_d;
      berr_q  <= berr_d;
    end
  end

  // Strobes are registered versions of the decision, so every output is a
  // flop and ack/irq never reach minx combinationally.
  always_comb begin
    state_d = state_q;
    minx_d  = minx_q;
    tcnt_d  = tcnt_q;
    scnt_d  = scnt_q;
    prog_d  = 1'b1;
    shen_d  = 1'b0;
    berr_d  = 1'b0;
    unique case (state_q)
      S_RUN: begin
        unique case (seq_op)
          OP_INC: minx_d = minx_q + 8'd1;
          OP_DISPATCH: begin
            if (irq_pending)      minx_d = UADR_IRQ;
            else if (instr_valid) minx_d = dispatch_idx;
            else                  prog_d = 1'b0;
          end
          OP_WAITACK: begin
            if (ack) minx_d = minx_q + 8'd1;
            else begin
              state_d = S_WAIT;
              tcnt_d  = 8'd1;
              prog_d  = 1'b0;
            end
          end
          OP_SHIFT: begin
            if (shamt == 5'd0) minx_d = minx_q + 8'd1;
            else begin
              state_d = S_SHIFT;
              scnt_d  = shamt;
              shen_d  = 1'b1;
              prog_d  = 1'b0;
            end
          end
          default: ;
        endcase
      end
      S_WAIT: begin
        // ack outranks a coincident timeout
        if (ack) begin
          minx_d  = minx_q + 8'd1;
          state_d = S_RUN;
          tcnt_d  = '0;
        end else if (tcnt_q == TMO) begin
          minx_d  = UADR_BUSERR;
          berr_d  = 1'b1;
          state_d = S_RUN;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
          prog_d = 1'b0;
        end
      end
      S_SHIFT: begin
        if (scnt_q == 5'd1) begin
          minx_d  = minx_q + 8'd1;
          state_d = S_RUN;
          scnt_d  = '0;
        end else begin
          scnt_d = scnt_q - 5'd1;
          shen_d = 1'b1;
          prog_d = 1'b0;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  assign minx           = minx_q;
  assign progress_ucode = prog_q;
  assign shift_en       = shen_q;
  assign buserr         = berr_q;

endmodule

// File: tb/tb_m_useq.sv
// Directed bench for m_useq: expected outputs are queued as each step is
// driven and popped for comparison one edge later.
module tb_m_useq;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] seq_op;
  logic [7:0] dispatch_idx;
  logic       instr_valid, irq_pending, ack;
  logic [4:0] shamt;
  logic [7:0] minx;
  logic       progress_ucode, shift_en, buserr;

  localparam logic [1:0] INC = 2'd0, DSP = 2'd1, WACK = 2'd2, SHF = 2'd3;

  typedef struct {
    logic [7:0] m;
    logic       p, s, b;
    string      tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  m_useq dut (
    .clk(clk), .rst(rst), .seq_op(seq_op), .dispatch_idx(dispatch_idx),
    .instr_valid(instr_valid), .irq_pending(irq_pending), .ack(ack),
    .shamt(shamt), .minx(minx), .progress_ucode(progress_ucode),
    .shift_en(shift_en), .buserr(buserr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then
  // pop and compare just after the edge.
  task automatic cyc(input logic r, input logic [1:0] op, input logic [7:0] idx,
                     input logic iv, input logic irq, input logic ak, input logic [4:0] sh,
                     input logic [7:0] em, input logic ep, input logic es, input logic eb,
                     input string tag);
    exp_t e;
    rst = r; seq_op = op; dispatch_idx = idx; instr_valid = iv;
    irq_pending = irq; ack = ak; shamt = sh;
    q.push_back('{em, ep, es, eb, tag});
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else begin
      e = q.pop_front();
      chk({e.tag, ".minx"}, minx, e.m);
      chk({e.tag, ".prog"}, {7'd0, progress_ucode}, {7'd0, e.p});
      chk({e.tag, ".shen"}, {7'd0, shift_en}, {7'd0, e.s});
      chk({e.tag, ".berr"}, {7'd0, buserr}, {7'd0, e.b});
    end
  endtask

  initial begin
    // reset and stepping
    cyc(1, INC, 8'h00, 0, 0, 0, 5'd0, 8'h00, 1, 0, 0, "rst0");
    cyc(1, INC, 8'h00, 0, 0, 0, 5'd0, 8'h00, 1, 0, 0, "rst1");
    cyc(0, INC, 8'h00, 0, 0, 0, 5'd0, 8'h01, 1, 0, 0, "inc1");
    cyc(0, INC, 8'h00, 0, 0, 0, 5'd0, 8'h02, 1, 0, 0, "inc2");
    cyc(0, INC, 8'h00, 0, 0, 0, 5'd0, 8'h03, 1, 0, 0, "inc3");
    // wrap
    cyc(0, DSP, 8'hFF, 1, 0, 0, 5'd0, 8'hFF, 1, 0, 0, "dspFF");
    cyc(0, INC, 8'h00, 0, 0, 0, 5'd0, 8'h00, 1, 0, 0, "wrap");
    // dispatch stall then resolve
    for (int i = 0; i < 3; i++)
      cyc(0, DSP, 8'h42, 0, 0, 0, 5'd0, 8'h00, 0, 0, 0, "stall");
    cyc(0, DSP, 8'h42, 1, 0, 0, 5'd0, 8'h42, 1, 0, 0, "dsp42");
    // interrupt wins over a valid instruction
    cyc(0, DSP, 8'h42, 1, 1, 0, 5'd0, 8'hF0, 1, 0, 0, "irq");
    // zero-wait ack
    cyc(0, WACK, 8'h00, 0, 0, 1, 5'd0, 8'hF1, 1, 0, 0, "ack0");
    // ack on cycle 3; irq pending while waiting must be ignored
    cyc(0, WACK, 8'h42, 1, 1, 0, 5'd0, 8'hF1, 0, 0, 0, "wait1");
    cyc(0, DSP,  8'h42, 1, 1, 0, 5'd0, 8'hF1, 0, 0, 0, "wait2");
    cyc(0, DSP,  8'h42, 1, 1, 0, 5'd0, 8'hF1, 0, 0, 0, "wait3");
    cyc(0, DSP,  8'h42, 1, 1, 1, 5'd0, 8'hF2, 1, 0, 0, "ack3");
    // ack coincident with the final timeout cycle
    cyc(0, WACK, 8'h00, 0, 0, 0, 5'd0, 8'hF2, 0, 0, 0, "cw_issue");
    for (int i = 0; i < 14; i++)
      cyc(0, INC, 8'h00, 0, 0, 0, 5'd0, 8'hF2, 0, 0, 0, "cw_wait");
    cyc(0, INC, 8'h00, 0, 0, 1, 5'd0, 8'hF3, 1, 0, 0, "ack_at_tmo");
    // timeout
    cyc(0, WACK, 8'h00, 0, 0, 0, 5'd0, 8'hF3, 0, 0, 0, "to_issue");
    for (int i = 0; i < 14; i++)
      cyc(0, INC, 8'h00, 0, 0, 0, 5'd0, 8'hF3, 0, 0, 0, "to_wait");
    cyc(0, INC, 8'h00, 0, 0, 0, 5'd0, 8'hF8, 1, 0, 1, "timeout");
    cyc(0, INC, 8'h00, 0, 0, 0, 5'd0, 8'hF9, 1, 0, 0, "berr_off");
    cyc(0, INC, 8'h00, 0, 0, 0, 5'd0, 8'hFA, 1, 0, 0, "inc_fa");
    // shift by 5
    cyc(0, SHF, 8'h00, 0, 0, 0, 5'd5, 8'hFA, 0, 1, 0, "sh5_0");
    for (int i = 0; i < 4; i++)
      cyc(0, INC, 8'h00, 0, 0, 0, 5'd0, 8'hFA, 0, 1, 0, "sh5_n");
    cyc(0, INC, 8'h00, 0, 0, 0, 5'd0, 8'hFB, 1, 0, 0, "sh5_done");
    // shift by 0
    cyc(0, SHF, 8'h00, 0, 0, 0, 5'd0, 8'hFC, 1, 0, 0, "sh0");
    // reset on the third shift cycle
    cyc(0, SHF, 8'h00, 0, 0, 0, 5'd7, 8'hFC, 0, 1, 0, "sh7_0");
    cyc(0, INC, 8'h00, 0, 0, 0, 5'd0, 8'hFC, 0, 1, 0, "sh7_1");
    cyc(1, INC, 8'h00, 0, 0, 0, 5'd0, 8'h00, 1, 0, 0, "sh7_rst");
    cyc(0, INC, 8'h00, 0, 0, 0, 5'd0, 8'h01, 1, 0, 0, "post_rst");
    // shift by 1
    cyc(0, SHF, 8'h00, 0, 0, 0, 5'd1, 8'h01, 0, 1, 0, "sh1_0");
    cyc(0, INC, 8'h00, 0, 0, 0, 5'd0, 8'h02, 1, 0, 0, "sh1_done");

    if (q.size() != 0) begin
      checks++; failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/m_useq.md
Name: m_useq

Overview:
- Microcode sequencer for the midgetv ucode store (2-EBR or 3-EBR variant).
- Generates the registered micro-address `minx` and the `progress_ucode` hold strobe.
- Decides each cycle whether to step, dispatch a new instruction, wait for a bus ack, hold during multi-cycle shifts, or vector to interrupt or bus-error microcode.
- Sits between the instruction decoder / bus interface and the ucode store.

Parameters:
- UADR_RESET, 8'h00, micro-address loaded by reset.
- UADR_IRQ, 8'hF0, micro-address of the interrupt-entry routine.
- UADR_BUSERR, 8'hF8, micro-address of the bus-error/trap routine.
- ACK_TIMEOUT, 15, max cycles waited for `ack` before bus-error (1..255).

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- rst, input, 1, synchronous active-high reset.
- seq_op, input, 2, sequencing field of current ucode word: 0=INC, 1=DISPATCH, 2=WAITACK, 3=SHIFT.
- dispatch_idx, input, 8, entry micro-address from the instruction decoder.
- instr_valid, input, 1, `dispatch_idx` is valid this cycle.
- irq_pending, input, 1, enabled interrupt pending.
- ack, input, 1, bus/sram acknowledge.
- shamt, input, 5, shift amount for SHIFT.
- minx, output, 8, registered micro-address to the ucode store.
- progress_ucode, output, 1, 1 = ucode store advances; 0 = hold word.
- shift_en, output, 1, datapath performs one 1-bit shift this cycle.
- buserr, output, 1, one-cycle pulse on ack timeout.

Behaviour:
- States: RUN, WAIT, SHIFT. `seq_op` is only interpreted in RUN.
- Reset (`rst`=1 at edge):
  - minx=UADR_RESET, state=RUN.
  - progress_ucode=1, shift_en=0, buserr=0, counters=0.
  - Reset overrides every other event, including mid-WAIT and mid-SHIFT.
- RUN, INC:
  - minx<=minx+1, wrapping modulo 256 (8'hFF -> 8'h00).
  - progress_ucode=1.
- RUN, DISPATCH:
  - irq_pending=1 -> minx<=UADR_IRQ. Interrupt wins over `instr_valid`.
  - else instr_valid=1 -> minx<=dispatch_idx.
  - else minx held, progress_ucode=0. Stall repeats until one of the above.
  - irq_pending is sampled only here; no interrupt entry in any other op or state.
- RUN, WAITACK:
  - ack=1 in the same cycle -> minx<=minx+1, stay RUN (zero-wait).
  - else enter WAIT, tcnt<=1, progress_ucode=0, minx held.
- WAIT: progress_ucode=0 while waiting.
  - ack=1 -> minx<=minx+1, RUN, progress_ucode=1.
  - else tcnt==ACK_TIMEOUT -> minx<=UADR_BUSERR, buserr=1 for one cycle, RUN.
  - else tcnt<=tcnt+1.
  - ack and timeout in the same cycle: ack wins, no buserr.
- RUN, SHIFT:
  - shamt==0 -> behaves as INC, shift_en=0.
  - else scnt<=shamt, state SHIFT, shift_en=1, progress_ucode=0.
- SHIFT:
  - shift_en=1 every cycle; scnt decrements.
  - When scnt reaches 1: minx<=minx+1, RUN, progress_ucode=1.
  - Exactly `shamt` cycles of shift_en=1 in total, counting the entry cycle.
- Latency: minx changes one edge after the decision inputs; ucode store adds its own read cycle.
- minx never changes while progress_ucode=0, except:
  - the cycle leaving WAIT/SHIFT;
  - the cycle a DISPATCH stall resolves.
- Outputs are registered or decoded from registered state only; no combinational path from `ack` or `irq_pending` to `minx`.
- Expected size: 150-250 lines.

Test Plan:
- Reset: rst=1 for 2 cycles, then seq_op=INC for 3 cycles -> minx 8'h00, 8'h01, 8'h02, 8'h03; progress_ucode=1 throughout.
- Wrap/dispatch:
  - minx=8'hFF with INC -> 8'h00.
  - DISPATCH, instr_valid=0 for 3 cycles, then instr_valid=1, dispatch_idx=8'h42 -> minx held, progress_ucode=0 for 3 cycles; then minx=8'h42.
- IRQ priority: DISPATCH with irq_pending=1, instr_valid=1, dispatch_idx=8'h42 -> minx=8'hF0. irq_pending during WAIT -> ignored.
- Ack:
  - WAITACK with ack on cycle 0 -> minx+1 next edge, no stall.
  - ack on 4th wait cycle -> 3 cycles progress_ucode=0, then minx+1.
  - ack coincident with tcnt==15 -> minx+1, buserr=0.
- Timeout: WAITACK, ack never asserted -> after 15 wait cycles minx=8'hF8, buserr pulses exactly 1 cycle.
- Shift and reset:
  - SHIFT, shamt=5 -> shift_en=1 for exactly 5 cycles, progress_ucode=0 for those 5, then minx+1.
  - shamt=0 -> immediate minx+1, shift_en never 1.
  - rst asserted on 3rd shift cycle -> minx=8'h00, shift_en=0 next edge.
